// File: rtl/video_boxcar_filter_if.sv
// Sample/output bundle for video_boxcar_filter.
// master drives samples and controls; slave is the filter.
interface video_boxcar_filter_if #(
  parameter int C_DAT_W = 9
);
  logic               CK_EE_i;
  logic [C_DAT_W-1:0] DAT_i;
  logic [2:0]         TAPS_LOG2_i;
  logic               BYPASS_i;
  logic [C_DAT_W-1:0] QQ_o;
  logic               QQ_VLD_o;

  modport master (
    output CK_EE_i, DAT_i, TAPS_LOG2_i, BYPASS_i,
    input  QQ_o, QQ_VLD_o
  );

  modport slave (
    input  CK_EE_i, DAT_i, TAPS_LOG2_i, BYPASS_i,
    output QQ_o, QQ_VLD_o
  );
endinterface

// File: rtl/video_boxcar_filter.sv
// Running-sum boxcar averager for the composite video sample stream.
// Define VIDEO_BOXCAR_FILTER_ROUND_EN for round-half-up output.
module video_boxcar_filter #(
  parameter int C_DAT_W    = 9,
  parameter int C_MAX_LOG2 = 3
) (
  input logic CK_i,
  input logic XAR_i,
  video_boxcar_filter_if.slave bus
);
  localparam int DEPTH = 1 << C_MAX_LOG2;
  localparam int SUM_W = C_DAT_W + C_MAX_LOG2;
  localparam int CNT_W = C_MAX_LOG2 + 1;
  localparam int IDX_W = C_MAX_LOG2;
  localparam logic [2:0] K_MAX = 3'(C_MAX_LOG2);

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic               k_vld_q, k_vld_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_DAT_W-1:0] dly_q [DEPTH];
  logic [C_DAT_W-1:0] dly_d [DEPTH];
  logic [C_DAT_W-1:0] qq_q, qq_d;
  logic               qq_vld_q, qq_vld_d;

  logic [2:0]         k_clamp;
  logic [2:0]         k_eff;
  logic               tap_chg;
  logic [CNT_W-1:0]   taps;
  logic [C_DAT_W-1:0] old;

`ifdef VIDEO_BOXCAR_FILTER_ROUND_EN
  localparam int RND_W = SUM_W + 1;
  localparam logic [RND_W-1:0] QQ_MAX =
    RND_W'((1 << C_DAT_W) - 1);
  logic [RND_W-1:0] rnd_inc;
  logic [RND_W-1:0] rnd_sum;
  logic [RND_W-1:0] rnd_sh;
`endif

  always_comb begin
    k_clamp = (bus.TAPS_LOG2_i > K_MAX) ?
              K_MAX : bus.TAPS_LOG2_i;
    // K is taken straight from the pins on the first edge after reset
    k_eff   = k_vld_q ? k_q : k_clamp;
    tap_chg = k_vld_q && (k_clamp != k_q);
    taps    = CNT_W'(1) << k_eff;
    old     = dly_q[IDX_W'(taps - CNT_W'(1))];

    state_d  = state_q;
    k_d      = k_eff;
    k_vld_d  = 1'b1;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    qq_d     = qq_q;
    qq_vld_d = qq_vld_q;
`ifdef VIDEO_BOXCAR_FILTER_ROUND_EN
    rnd_inc  = '0;
    rnd_sum  = '0;
    rnd_sh   = '0;
`endif

    if (tap_chg) begin
      k_d      = k_clamp;
      sum_d    = '0;
      cnt_d    = '0;
      dly_d    = '{default: '0};
      state_d  = S_FILL;
      qq_vld_d = 1'b0;
    end else if (bus.CK_EE_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        dly_d[i] = dly_q[i-1];
      end
      dly_d[0] = bus.DAT_i;

      unique case (state_q)
        S_FILL: begin
          sum_d = sum_q + SUM_W'(bus.DAT_i);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == taps) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          sum_d = sum_q + SUM_W'(bus.DAT_i)
                - SUM_W'(old);
        end
        default: state_d = S_FILL;
      endcase

      if (bus.BYPASS_i) begin
        qq_d     = bus.DAT_i;
        qq_vld_d = 1'b1;
      end else begin
`ifdef VIDEO_BOXCAR_FILTER_ROUND_EN
        rnd_inc = (k_eff == 3'd0) ? '0 :
                  (RND_W'(1) << (k_eff - 3'd1));
        rnd_sum = RND_W'(sum_d) + rnd_inc;
        rnd_sh  = rnd_sum >> k_eff;
        qq_d    = (rnd_sh > QQ_MAX) ?
                  C_DAT_W'(QQ_MAX) : C_DAT_W'(rnd_sh);
`else
        qq_d    = C_DAT_W'(sum_d >> k_eff);
`endif
        qq_vld_d = (state_d == S_RUN);
      end
    end
  end

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      state_q  <= S_FILL;
      k_q      <= '0;
      k_vld_q  <= 1'b0;
      sum_q    <= '0;
      cnt_q    <= '0;
      dly_q    <= '{default: '0};
      qq_q     <= '0;
      qq_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      k_vld_q  <= k_vld_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      qq_q     <= qq_d;
      qq_vld_q <= qq_vld_d;
    end
  end

  assign bus.QQ_o     = qq_q;
  assign bus.QQ_VLD_o = qq_vld_q;
endmodule

// File: tb/tb_video_boxcar_filter.sv
// Scoreboard bench for video_boxcar_filter (9-bit, depth 8).
// Expected values are hand-computed; rounding tables follow the build macro.
module tb_video_boxcar_filter;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  video_boxcar_filter_if #(.C_DAT_W(W)) bus ();

  video_boxcar_filter #(
    .C_DAT_W(W),
    .C_MAX_LOG2(3)
  ) dut (
    .CK_i(clk),
    .XAR_i(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    qq;
    bit    vld;
    bit    chk_qq;
    string nm;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

`ifdef VIDEO_BOXCAR_FILTER_ROUND_EN
  int FILL100[8] = '{13, 25, 38, 50, 63, 75, 88, 100};
  int DECAY[8]   = '{88, 75, 63, 50, 38, 25, 13, 0};
  int RAMP[8]    = '{64, 128, 192, 256, 319, 383, 447, 511};
  int DROP[2]    = '{7, 8};
`else
  int FILL100[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
  int DECAY[8]   = '{87, 75, 62, 50, 37, 25, 12, 0};
  int RAMP[8]    = '{63, 127, 191, 255, 319, 383, 447, 511};
  int DROP[2]    = '{6, 7};
`endif

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic step(input bit ee, input int dat, input int tl,
                      input bit byp, input int eq, input bit ev,
                      input bit cq, input string nm);
    exp_t e;
    @(negedge clk);
    bus.CK_EE_i     = ee;
    bus.DAT_i       = W'(dat);
    bus.TAPS_LOG2_i = 3'(tl);
    bus.BYPASS_i    = byp;
    if (ee) begin
      e.qq = eq;
      e.vld = ev;
      e.chk_qq = cq;
      e.nm = nm;
      sb.push_back(e);
    end
  endtask

  initial begin : mon
    exp_t e;
    bit acc;
    int lq;
    bit lq_ok;
    bit lv;
    lq = 0;
    lq_ok = 1'b1;
    lv = 1'b0;
    forever begin
      @(posedge clk);
      acc = bus.CK_EE_i && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        lq = 0;
        lq_ok = 1'b1;
        lv = 1'b0;
      end else if (acc) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.chk_qq) begin
            chk({e.nm, "_qq"}, int'(bus.QQ_o), e.qq);
            lq = e.qq;
            lq_ok = 1'b1;
          end else begin
            lq_ok = 1'b0;
          end
          chk({e.nm, "_vld"}, int'(bus.QQ_VLD_o), int'(e.vld));
          lv = e.vld;
        end
      end else begin
        if (lq_ok) chk("hold_qq", int'(bus.QQ_o), lq);
        chk("hold_vld", int'(bus.QQ_VLD_o), int'(lv));
      end
    end
  end

  initial begin : stim
    bus.CK_EE_i     = 1'b0;
    bus.DAT_i       = '0;
    bus.TAPS_LOG2_i = 3'd3;
    bus.BYPASS_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_qq", int'(bus.QQ_o), 0);
    chk("rst_vld", int'(bus.QQ_VLD_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      step(1, 100, 3, 0, FILL100[i], i == 7, 1, "fill100");
    repeat (2) step(1, 100, 3, 0, 100, 1, 1, "run100");
    for (int i = 0; i < 8; i++)
      step(1, 0, 3, 0, DECAY[i], 1, 1, "decay");
    for (int i = 0; i < 8; i++)
      step(1, 511, 3, 0, RAMP[i], 1, 1, "step511");

    step(1, 511, 2, 0, 0, 0, 0, "tapchg32");
    for (int i = 0; i < 4; i++)
      step(1, 40, 2, 0, (i + 1) * 10, i == 3, 1, "refill4");
    step(1, 80, 7, 0, 0, 0, 0, "tapchg7");
    for (int i = 0; i < 8; i++)
      step(1, 80, 7, 0, (i + 1) * 10, i == 7, 1, "clampfill");
    step(1, 80, 3, 0, 80, 1, 1, "clamp_k3");
    step(1, 80, 7, 0, 80, 1, 1, "clamp_k7");

    step(1, 0, 1, 0, 0, 0, 0, "tapchg1");
    for (int i = 0; i < 6; i++) begin
      step(1, (i % 2) ? 200 : 0, 1, 0, (i == 0) ? 0 : 100,
           i != 0, 1, "ee1of4");
      for (int j = 0; j < 3; j++)
        step(0, (i * 97 + j * 41 + 5) % 512, 1, 0, 0, 0, 0, "idle");
    end

    step(1, 0, 3, 1, 0, 0, 0, "tapchg3");
    for (int i = 0; i < 10; i++)
      step(1, i, 3, 1, i, 1, 1, "bypass");
    step(1, 10, 3, 0, DROP[0], 1, 1, "byp_drop0");
    step(1, 11, 3, 0, DROP[1], 1, 1, "byp_drop1");

    @(negedge clk);
    #2;
    bus.CK_EE_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_qq", int'(bus.QQ_o), 0);
    chk("async_rst_vld", int'(bus.QQ_VLD_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      step(1, 100, 3, 0, FILL100[i], i == 7, 1, "rst_refill");
    step(1, 100, 3, 0, 100, 1, 1, "rst_run");
    step(0, 0, 3, 0, 0, 0, 0, "idle");

    for (int i = 0; i < 50 && sb.size() > 0; i++)
      @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
